readout_sequencer: RTL and testbench
====================================

// Module: readout_sequencer
// PURPOSE
//  Shot-level controller for the qubit readout chain (timing/sampler/multiplier/integrator).
//  Armed by the host for N shots; per shot: waits for a trigger edge, counts the programmed delay,
//  pulses start_collect, waits for iq_valid, then presents the I/Q result on a valid/ready port.
//  Gates host config writes so parameters never change mid-acquisition.
// PARAMETERS
//  SHOT_W          16     width of shot count / index
//  DELAY_W         14     width of trigger-to-collect delay (clk100 cycles)
//  DATA_W          32     width of integrated I and Q results
//  TIMEOUT_CYCLES  4096   max cycles in COLLECT without iq_valid (READOUT_TIMEOUT_EN only)
// PORTS
//  clk100         in   1        system clock
//  reset_n        in   1        asynchronous active-low reset
//  arm            in   1        1-cycle pulse: start a run; samples num_shots, delay_time
//  abort          in   1        level: return to IDLE next cycle
//  num_shots      in   SHOT_W   shots per run
//  delay_time     in   DELAY_W  trigger-edge-to-start delay
//  trigger        in   1        external trigger, rising edge used
//  start_collect  out  1        1-cycle pulse to sampler/integrator
//  iq_valid       in   1        integrator result strobe
//  i_val, q_val   in   DATA_W   integrator results
//  res_valid      out  1        result held valid until accepted
//  res_ready      in   1        downstream accepts when res_valid & res_ready
//  res_i, res_q   out  DATA_W   captured results
//  res_shot       out  SHOT_W   0-based index of presented shot
//  cfg_wr_req     in   1        host config write request (MEM wrEn)
//  cfg_wr_gnt     out  1        = cfg_wr_req & (state==IDLE), combinational
//  busy           out  1        state != IDLE
//  done           out  1        1-cycle pulse after last shot accepted
//  overrun        out  1        sticky; cleared by accepted arm
//  timeout_err    out  1        sticky; cleared by accepted arm (0 without macro)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters, result regs 0; trigger edge-detect reg 0.
//  - States: IDLE, ARMED, DELAY, COLLECT, HOLD.
//  - IDLE: arm -> latch num_shots/delay_time, shot_cnt=0, clear overrun/timeout_err, go ARMED;
//    arm with num_shots==0 -> done pulse next cycle, stay IDLE.
//  - ARMED: registered rising edge of trigger -> DELAY with cnt=delay_time.
//  - DELAY: cnt decrements each cycle; at cnt==0 assert start_collect that cycle, go COLLECT
//    (delay_time=0 -> start_collect the cycle after edge detection; delay_time=D -> D cycles later).
//  - COLLECT: iq_valid -> capture i_val/q_val, res_shot=shot_cnt, res_valid=1 next cycle, go HOLD.
//  - HOLD: on res_valid&res_ready: res_valid=0, shot_cnt++; if shot_cnt+1==num_shots -> done pulse,
//    IDLE; else ARMED. res_* stable while res_valid & !res_ready.
//  - Trigger edge in DELAY/COLLECT/HOLD: ignored, sets overrun. iq_valid outside COLLECT: ignored,
//    sets overrun. arm while busy: ignored.
//  - abort (any state, highest priority): IDLE next cycle, res_valid=0, no done, sticky flags kept.
//  - Simultaneous abort and res handshake: abort wins; shot not counted.
//  - shot_cnt never wraps: run ends at num_shots (max 2^SHOT_W-1).
// CONFIGURATION
//  READOUT_TIMEOUT_EN defined: COLLECT counts cycles; reaching TIMEOUT_CYCLES without iq_valid sets
//    timeout_err and returns to IDLE (no done). Undefined: COLLECT waits indefinitely; timeout_err=0.
// STRUCTURE
//  - readout_pkg: state enum rdo_state_t, widths SHOT_W/DELAY_W/DATA_W defaults.
//  - Sub-module readout_delay_timer: loadable down-counter, load/zero-flag interface.
// TESTING
//  1 reset_n low mid-DELAY -> all outputs 0 same cycle, IDLE after release.
//  2 arm num_shots=3, delay=5, 3 triggers, res_ready=1 -> start_collect 5 cycles after each edge,
//    res_shot 0,1,2, one done pulse.
//  3 res_ready held 0 for 10 cycles in HOLD -> res_* stable; extra trigger sets overrun, no extra start.
//  4 delay=0, num_shots=0 -> arm yields done next cycle, no start_collect; cfg_wr_gnt follows req.
//  5 abort during COLLECT with iq_valid same cycle -> IDLE, res_valid stays 0, no done.
//  6 READOUT_TIMEOUT_EN, TIMEOUT_CYCLES=16, no iq_valid -> timeout_err=1 after 16 cycles, IDLE.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and default widths for the qubit readout sequencer.
package readout_pkg;

    localparam int unsigned SHOT_W_DEF  = 16;
    localparam int unsigned DELAY_W_DEF = 14;
    localparam int unsigned DATA_W_DEF  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StDelay,
        StCollect,
        StHold
    } rdo_state_t;

endpackage

// File: rtl/readout_delay_timer.sv
// Loadable down-counter for the trigger-to-collect delay.
// zero is high whenever the count is 0.
module readout_delay_timer #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Shot-level controller for the qubit readout chain.
// Optional COLLECT watchdog enabled by defining READOUT_TIMEOUT_EN.
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int unsigned SHOT_W         = SHOT_W_DEF,
    parameter int unsigned DELAY_W        = DELAY_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk100,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [SHOT_W-1:0] num_shots,
    input  logic [DELAY_W-1:0] delay_time,
    input  logic              trigger,
    output logic              start_collect,
    input  logic              iq_valid,
    input  logic [DATA_W-1:0] i_val,
    input  logic [DATA_W-1:0] q_val,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_i,
    output logic [DATA_W-1:0] res_q,
    output logic [SHOT_W-1:0] res_shot,
    input  logic              cfg_wr_req,
    output logic              cfg_wr_gnt,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              timeout_err
);

    rdo_state_t state_q, state_d;

    logic [SHOT_W-1:0]  shots_q, shots_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [SHOT_W-1:0]  shot_cnt_q, shot_cnt_d;
    logic [DATA_W-1:0]  res_i_q, res_i_d, res_q_q, res_q_d;
    logic [SHOT_W-1:0]  res_shot_q, res_shot_d;
    logic               res_valid_q, res_valid_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic               trig_q;
    logic               trig_edge;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic               tmo_hit;

    assign trig_edge = trigger & ~trig_q;

    readout_delay_timer #(
        .WIDTH(DELAY_W)
    ) u_delay_timer (
        .clk      (clk100),
        .rst_n    (reset_n),
        .load     (tmr_load),
        .load_val (delay_q),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

`ifdef READOUT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Counts cycles spent in COLLECT; cleared whenever the state is left.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != StCollect) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        shots_d       = shots_q;
        delay_d       = delay_q;
        shot_cnt_d    = shot_cnt_q;
        res_i_d       = res_i_q;
        res_q_d       = res_q_q;
        res_shot_d    = res_shot_q;
        res_valid_d   = res_valid_q;
        done_d        = 1'b0;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        start_collect = 1'b0;

        if (trig_edge && (state_q inside {StDelay, StCollect, StHold})) begin
            overrun_d = 1'b1;
        end
        if (iq_valid && (state_q != StCollect)) begin
            overrun_d = 1'b1;
        end

        if (abort) begin
            state_d     = StIdle;
            res_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        shots_d    = num_shots;
                        delay_d    = delay_time;
                        shot_cnt_d = '0;
                        overrun_d  = 1'b0;
                        timeout_d  = 1'b0;
                        if (num_shots == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (trig_edge) begin
                        tmr_load = 1'b1;
                        state_d  = StDelay;
                    end
                end
                StDelay: begin
                    if (tmr_zero) begin
                        start_collect = 1'b1;
                        state_d       = StCollect;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                StCollect: begin
                    if (iq_valid) begin
                        res_i_d     = i_val;
                        res_q_d     = q_val;
                        res_shot_d  = shot_cnt_q;
                        res_valid_d = 1'b1;
                        state_d     = StHold;
                    end else if (tmo_hit) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
                StHold: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_d = 1'b0;
                        shot_cnt_d  = shot_cnt_q + 1'b1;
                        // Widened compare so num_shots at full scale cannot wrap.
                        if (({1'b0, shot_cnt_q} + 1'b1) == {1'b0, shots_q}) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StArmed;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            shots_q     <= '0;
            delay_q     <= '0;
            shot_cnt_q  <= '0;
            res_i_q     <= '0;
            res_q_q     <= '0;
            res_shot_q  <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shots_q     <= shots_d;
            delay_q     <= delay_d;
            shot_cnt_q  <= shot_cnt_d;
            res_i_q     <= res_i_d;
            res_q_q     <= res_q_d;
            res_shot_q  <= res_shot_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            trig_q      <= trigger;
        end
    end

    assign busy        = (state_q != StIdle);
    assign cfg_wr_gnt  = cfg_wr_req & (state_q == StIdle);
    assign res_valid   = res_valid_q;
    assign res_i       = res_i_q;
    assign res_q       = res_q_q;
    assign res_shot    = res_shot_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer: run table plus hand-written corner sequences.
module tb_readout_sequencer;

    logic        clk100 = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm = 1'b0, abort = 1'b0, trigger = 1'b0, iq_valid = 1'b0;
    logic        res_ready = 1'b0, cfg_wr_req = 1'b0;
    logic [15:0] num_shots = '0;
    logic [13:0] delay_time = '0;
    logic [31:0] i_val = '0, q_val = '0;
    logic        start_collect, res_valid, cfg_wr_gnt, busy, done, overrun, timeout_err;
    logic [31:0] res_i, res_q;
    logic [15:0] res_shot;

    readout_sequencer #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk100        (clk100),
        .reset_n       (reset_n),
        .arm           (arm),
        .abort         (abort),
        .num_shots     (num_shots),
        .delay_time    (delay_time),
        .trigger       (trigger),
        .start_collect (start_collect),
        .iq_valid      (iq_valid),
        .i_val         (i_val),
        .q_val         (q_val),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_i         (res_i),
        .res_q         (res_q),
        .res_shot      (res_shot),
        .cfg_wr_req    (cfg_wr_req),
        .cfg_wr_gnt    (cfg_wr_gnt),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        logic [15:0] n;
        logic [13:0] d;
        bit          stall;
        int          exp_lat;
        bit          exp_ovr;
    } vec_t;

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        logic [15:0] shot;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];
    int   checks = 0;
    int   failures = 0;
    int   n_start = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    // Scoreboard consumer and pulse counters, sampled mid-cycle.
    always @(negedge clk100) begin
        if (reset_n) begin
            if (start_collect) n_start++;
            if (done) n_done++;
            if (res_valid && res_ready && !abort) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res_i", res_i, e.i);
                    check("res_q", res_q, e.q);
                    check("res_shot", res_shot, e.shot);
                end
            end
        end
    end

    task automatic wait_start(input int exp_lat);
        int lat;
        lat = 0;
        trigger = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            trigger = 1'b0;
            lat++;
            if (start_collect) break;
        end
        check("start_latency", lat, exp_lat);
    endtask

    task automatic run_vec(input vec_t v);
        int          d0, s0;
        exp_t        e;
        logic [31:0] si, sq;
        logic [15:0] sshot;
        bit          stable;
        d0 = n_done;
        s0 = n_start;
        arm = 1'b1;
        num_shots = v.n;
        delay_time = v.d;
        tick();
        arm = 1'b0;
        check("busy_after_arm", busy, v.n != 0);
        if (v.n == 0) check("done_zero_shots", done, 1);
        for (int s = 0; s < int'(v.n); s++) begin
            res_ready = !v.stall;
            wait_start(v.exp_lat);
            tick();
            e.i = $urandom;
            e.q = $urandom;
            e.shot = 16'(s);
            iq_valid = 1'b1;
            i_val = e.i;
            q_val = e.q;
            sb.push_back(e);
            tick();
            iq_valid = 1'b0;
            if (v.stall) begin
                si = res_i;
                sq = res_q;
                sshot = res_shot;
                stable = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    if (k == 3) trigger = 1'b1;
                    if (k == 4) trigger = 1'b0;
                    stable &= res_valid && (res_i == si) && (res_q == sq) && (res_shot == sshot);
                end
                check("hold_stable", stable, 1);
                check("overrun_hold_trigger", overrun, 1);
                res_ready = 1'b1;
            end
            for (int k = 0; k < 8; k++) begin
                tick();
                if (!res_valid) break;
            end
            check("res_valid_drop", res_valid, 0);
        end
        tick();
        check("done_count", n_done - d0, 1);
        check("start_count", n_start - s0, v.n);
        check("idle_after_run", busy, 0);
        check("overrun_after_run", overrun, v.exp_ovr);
    endtask

    initial begin
        int d0, n;
        vecs[0] = '{n: 16'd3, d: 14'd5,  stall: 1'b0, exp_lat: 6,  exp_ovr: 1'b0};
        vecs[1] = '{n: 16'd2, d: 14'd0,  stall: 1'b1, exp_lat: 1,  exp_ovr: 1'b1};
        vecs[2] = '{n: 16'd0, d: 14'd0,  stall: 1'b0, exp_lat: 1,  exp_ovr: 1'b0};
        vecs[3] = '{n: 16'd1, d: 14'd13, stall: 1'b0, exp_lat: 14, exp_ovr: 1'b0};

        repeat (3) tick();
        check("reset_state", {busy, start_collect, res_valid, done, overrun, timeout_err,
                              cfg_wr_gnt, res_i, res_shot}, 0);
        reset_n = 1'b1;
        tick();

        cfg_wr_req = 1'b1;
        #1 check("gnt_idle_req", cfg_wr_gnt, 1);
        cfg_wr_req = 1'b0;
        #1 check("gnt_idle_noreq", cfg_wr_gnt, 0);

        // Asynchronous reset in the middle of DELAY.
        arm = 1'b1;
        num_shots = 16'd1;
        delay_time = 14'd10;
        tick();
        arm = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        check("busy_in_delay", busy, 1);
        reset_n = 1'b0;
        #1 check("reset_async_outputs", {busy, start_collect, res_valid, done, overrun,
                                         timeout_err, cfg_wr_gnt, res_i, res_shot}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_after_reset", busy, 0);

        res_ready = 1'b1;
        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Abort in COLLECT coinciding with iq_valid.
        d0 = n_done;
        res_ready = 1'b1;
        arm = 1'b1;
        num_shots = 16'd2;
        delay_time = 14'd2;
        tick();
        arm = 1'b0;
        wait_start(3);
        tick();
        cfg_wr_req = 1'b1;
        #1 check("gnt_busy", cfg_wr_gnt, 0);
        cfg_wr_req = 1'b0;
        abort = 1'b1;
        iq_valid = 1'b1;
        i_val = 32'hdead_beef;
        tick();
        abort = 1'b0;
        iq_valid = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_res_valid", res_valid, 0);
        repeat (3) tick();
        check("abort_res_valid_later", res_valid, 0);
        check("abort_no_done", n_done - d0, 0);
        check("abort_no_overrun", overrun, 0);

        // COLLECT with no iq_valid.
        d0 = n_done;
        arm = 1'b1;
        num_shots = 16'd1;
        delay_time = 14'd0;
        tick();
        arm = 1'b0;
        wait_start(1);
`ifdef READOUT_TIMEOUT_EN
        n = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            n++;
            if (!busy) break;
        end
        check("timeout_cycles", n, 17);
        check("timeout_err_set", timeout_err, 1);
        tick();
        check("timeout_no_done", n_done - d0, 0);
        arm = 1'b1;
        num_shots = 16'd0;
        tick();
        arm = 1'b0;
        check("timeout_err_cleared", timeout_err, 0);
        tick();
`else
        n = 0;
        repeat (40) tick();
        check("collect_waits", busy, 1);
        check("timeout_err_zero", timeout_err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_from_collect", busy, 0);
        tick();
        check("collect_no_done", n_done - d0, 0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
